// File: rtl/dbus_ram_responder_if.sv
// Memory-stage data bus between the CPU core (master) and the RAM responder (slave).
interface dbus_ram_responder_if;
   logic [31:0] DADDR;
   logic [31:0] DATAO;
   logic [2:0]  DLEN;
   logic        DRD;
   logic        DWR;
   logic [31:0] DATAI;
   logic        DHLT;

   modport master (
      output DADDR, DATAO, DLEN, DRD, DWR,
      input  DATAI, DHLT
   );

   modport slave (
      input  DADDR, DATAO, DLEN, DRD, DWR,
      output DATAI, DHLT
   );
endinterface

// File: rtl/dbus_ram_responder.sv
// Data-bus RAM responder: word-organised RAM serving byte/half/word loads and
// stores with byte-lane steering, misaligned split into two word accesses, and
// WAIT extra stall cycles per word access.
module dbus_ram_responder #(
   parameter int unsigned ADDR_W = 12,
   parameter int unsigned WAIT   = 0
) (
   input logic                 CLK,
   input logic                 RES,
   dbus_ram_responder_if.slave bus
);

   typedef enum logic [1:0] {IDLE, ACC0, ACC1, DONE} state_t;

   state_t            state, state_nx;
   logic [3:0]        wcnt;
   logic [ADDR_W+1:0] a_q;
   logic [2:0]        len_q;
   logic [31:0]       wd_q;
   logic              rd_q, wr_q;
   logic [31:0]       lo_q;
   logic [31:0]       datai_q;
   logic [31:0]       mem [2**ADDR_W];

   logic              legal, req, last, split;
   logic              dhlt, latch, commit, ld_lo, ld_out;
   logic [1:0]        o;
   logic [ADDR_W-1:0] w0, w1, idx;
   logic [3:0]        m, be;
   logic [7:0]        be8;
   logic [63:0]       wd64, r64;
   logic [31:0]       rmask, rword, wword;
   logic              unused_bits;

   // Request qualification and lane/address decode from the latched request
   always_comb begin
      legal = (bus.DLEN == 3'b001) || (bus.DLEN == 3'b010) || (bus.DLEN == 3'b100);
      req   = (bus.DRD | bus.DWR) & legal;
      last  = (wcnt == 4'(WAIT));
      o     = a_q[1:0];
      w0    = a_q[ADDR_W+1:2];
      w1    = w0 + {{(ADDR_W-1){1'b0}}, 1'b1};
      split = ((len_q == 3'b100) && (o != 2'b00)) || ((len_q == 3'b010) && (o == 2'b11));
      case (len_q)
         3'b001:  begin m = 4'b0001; rmask = 32'h0000_00FF; end
         3'b010:  begin m = 4'b0011; rmask = 32'h0000_FFFF; end
         default: begin m = 4'b1111; rmask = 32'hFFFF_FFFF; end
      endcase
      be8   = {4'b0000, m} << o;
      wd64  = {32'h0, wd_q} << {o, 3'b000};
      idx   = (state == ACC1) ? w1 : w0;
      be    = (state == ACC1) ? be8[7:4] : be8[3:0];
      wword = (state == ACC1) ? wd64[63:32] : wd64[31:0];
      rword = mem[idx];
      // ACC1 combines the registered low word with the high word being read now
      r64   = (state == ACC1) ? ({rword, lo_q} >> {o, 3'b000})
                              : ({32'h0, rword} >> {o, 3'b000});
   end

   // Next-state and control strobes
   always_comb begin
      state_nx = state;
      dhlt     = 1'b0;
      latch    = 1'b0;
      commit   = 1'b0;
      ld_lo    = 1'b0;
      ld_out   = 1'b0;
      case (state)
         IDLE: begin
            dhlt = req;
            if (req) begin
               latch    = 1'b1;
               state_nx = ACC0;
            end
         end
         ACC0: begin
            dhlt = 1'b1;
            if (last) begin
               commit = wr_q;
               if (split) begin
                  ld_lo    = rd_q;
                  state_nx = ACC1;
               end else begin
                  ld_out   = rd_q;
                  state_nx = DONE;
               end
            end
         end
         ACC1: begin
            dhlt = 1'b1;
            if (last) begin
               commit   = wr_q;
               ld_out   = rd_q;
               state_nx = DONE;
            end
         end
         default: state_nx = IDLE;
      endcase
   end

   assign bus.DHLT    = dhlt;
   assign bus.DATAI   = datai_q;
   assign unused_bits = ^{bus.DADDR[31:ADDR_W+2], r64[63:32]};

   // State register
   always_ff @(posedge CLK) begin
      if (RES) state <= IDLE;
      else     state <= state_nx;
   end

   // Wait-state counter, runs 0..WAIT within each word access
   always_ff @(posedge CLK) begin
      if (RES)                                wcnt <= '0;
      else if ((state == ACC0) || (state == ACC1)) wcnt <= last ? 4'd0 : wcnt + 4'd1;
      else                                    wcnt <= '0;
   end

   // Request capture on acceptance; a combined rd+wr is treated as store only
   always_ff @(posedge CLK) begin
      if (RES) begin
         a_q   <= '0;
         len_q <= '0;
         wd_q  <= '0;
         rd_q  <= 1'b0;
         wr_q  <= 1'b0;
      end else if (latch) begin
         a_q   <= bus.DADDR[ADDR_W+1:0];
         len_q <= bus.DLEN;
         wd_q  <= bus.DATAO;
         rd_q  <= bus.DRD & ~bus.DWR;
         wr_q  <= bus.DWR;
      end
   end

   // Load data: low word of a split load, then the aligned and masked result
   always_ff @(posedge CLK) begin
      if (RES) begin
         lo_q    <= '0;
         datai_q <= '0;
      end else begin
         if (ld_lo)  lo_q    <= rword;
         if (ld_out) datai_q <= r64[31:0] & rmask;
      end
   end

   // Byte-enabled RAM write, suppressed while reset is asserted
   always_ff @(posedge CLK) begin
      if (commit && !RES) begin
         for (int unsigned b = 0; b < 4; b++) begin
            if (be[b]) mem[idx][8*b +: 8] <= wword[8*b +: 8];
         end
      end
   end

endmodule
